// File: rtl/mpt_walk_arbiter_if.sv
// ---------------------------------------------------------------------------
// mpt_walk_arbiter_if
// Bundle of the requester-side and walker-side signals of the MPT walk
// arbiter. Signal names keep their arbiter-relative _i/_o suffixes so that
// waveforms and the arbiter source read the same.
//
//   slave  : the arbiter's view (consumes requests and walker results,
//            produces grants, responses and the walker command).
//   master : the environment's view (requesters plus walker).
//
// Handshakes:
//   req_valid_i[i]/req_ready_o[i] : transfer when both are 1 on a rising
//   clock edge; the requester holds valid, SPA and access stable until then.
//   walk_valid_o/walk_ready_i     : same rule; the arbiter holds the command.
//   rsp_valid_o and walk_done_i are single-cycle strobes with no
//   backpressure.
// ---------------------------------------------------------------------------
interface mpt_walk_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 64
);
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic [NUM_REQ*XLEN-1:0] req_spa_i;
   logic [NUM_REQ*2-1:0]    req_access_i;

   logic [NUM_REQ-1:0]      rsp_valid_o;
   logic                    rsp_allow_o;
   logic                    rsp_fault_o;
   logic [2:0]              rsp_cause_o;
   logic                    rsp_flushed_o;
   logic                    rsp_timeout_o;

   logic                    walk_valid_o;
   logic                    walk_ready_i;
   logic [XLEN-1:0]         walk_spa_o;
   logic [1:0]              walk_access_o;
   logic                    walk_flush_o;
   logic                    walk_done_i;
   logic                    walk_allow_i;
   logic                    walk_fault_i;
   logic [2:0]              walk_cause_i;

   modport slave (
      input  req_valid_i, req_spa_i, req_access_i,
      input  walk_ready_i, walk_done_i, walk_allow_i, walk_fault_i, walk_cause_i,
      output req_ready_o,
      output rsp_valid_o, rsp_allow_o, rsp_fault_o, rsp_cause_o,
      output rsp_flushed_o, rsp_timeout_o,
      output walk_valid_o, walk_spa_o, walk_access_o, walk_flush_o
   );

   modport master (
      output req_valid_i, req_spa_i, req_access_i,
      output walk_ready_i, walk_done_i, walk_allow_i, walk_fault_i, walk_cause_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_allow_o, rsp_fault_o, rsp_cause_o,
      input  rsp_flushed_o, rsp_timeout_o,
      input  walk_valid_o, walk_spa_o, walk_access_o, walk_flush_o
   );
endinterface

// File: rtl/mpt_walk_arbiter.sv
// ---------------------------------------------------------------------------
// mpt_walk_arbiter
// Shares one MPT walker between NUM_REQ requesters. One request at a time is
// granted with round-robin priority, forwarded to the walker (or answered
// directly in BARE mode), and the verdict is returned to its owner.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   mpt_mode_i   current mmpt MODE, 0 = BARE (walker bypassed)
//   flush_i      aborts any in-flight walk; blocks new grants while high
//   bus          mpt_walk_arbiter_if.slave (requests, responses, walker)
//   dbg_state_o  current FSM state (IDLE=0, ISSUE=1, WAIT_DONE=2, RESP=3)
// ---------------------------------------------------------------------------
module mpt_walk_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int XLEN           = 64,
   parameter int MODE_LEN       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [MODE_LEN-1:0] mpt_mode_i,
   input  logic                flush_i,
   mpt_walk_arbiter_if.slave   bus,
   output logic [1:0]          dbg_state_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_RESP      = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [PTR_W-1:0]   owner_q;
   logic [PTR_W-1:0]   winner;
   logic               win_found;
   logic               grant;
   logic               bypass;
   logic               wd_expire;
   logic [CNT_W-1:0]   cnt_q;
   logic [XLEN-1:0]    spa_q;
   logic [1:0]         access_q;
   logic               allow_q;
   logic               fault_q;
   logic [2:0]         cause_q;
   logic               flushed_q;
   logic               timeout_q;
   logic [NUM_REQ-1:0] ready_vec;
   logic [NUM_REQ-1:0] owner_vec;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      winner    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && bus.req_valid_i[idx]) begin
            win_found = 1'b1;
            winner    = idx[PTR_W-1:0];
         end
      end
   end

   // rst_ni gates the combinational grant so every output is 0 while reset
   // is held, even if requesters are already asserting valid.
   assign grant  = rst_ni && (state_q == ST_IDLE) && !flush_i && win_found;
   // The BARE decision is taken once, at acceptance; later mode changes
   // cannot reach the request because the FSM path is already chosen.
   assign bypass = (mpt_mode_i == '0);

   assign wd_expire = (state_q == ST_WAIT_DONE) && !bus.walk_done_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      ready_vec = '0;
      if (grant) ready_vec[winner] = 1'b1;
   end

   always_comb begin
      owner_vec = '0;
      if (state_q == ST_RESP) owner_vec[owner_q] = 1'b1;
   end

   // Next-state logic. Flush has priority over walk_ready_i/walk_done_i.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) state_d = bypass ? ST_RESP : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (flush_i)                state_d = ST_RESP;
            else if (bus.walk_ready_i)  state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (flush_i || bus.walk_done_i || wd_expire) state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         spa_q     <= '0;
         access_q  <= '0;
         allow_q   <= 1'b0;
         fault_q   <= 1'b0;
         cause_q   <= 3'd0;
         flushed_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  owner_q   <= winner;
                  spa_q     <= bus.req_spa_i[winner*XLEN +: XLEN];
                  access_q  <= bus.req_access_i[winner*2 +: 2];
                  allow_q   <= bypass;
                  fault_q   <= 1'b0;
                  cause_q   <= 3'd0;
                  flushed_q <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            ST_ISSUE: begin
               if (flush_i)               flushed_q <= 1'b1;
               else if (bus.walk_ready_i) cnt_q     <= '0;
            end
            ST_WAIT_DONE: begin
               if (flush_i) begin
                  flushed_q <= 1'b1;
               end else if (bus.walk_done_i) begin
                  // A faulting walk never reports allow.
                  allow_q <= bus.walk_allow_i & ~bus.walk_fault_i;
                  fault_q <= bus.walk_fault_i;
                  cause_q <= bus.walk_cause_i;
               end else if (wd_expire) begin
                  timeout_q <= 1'b1;
                  fault_q   <= 1'b1;
                  allow_q   <= 1'b0;
                  cause_q   <= 3'd0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               rr_ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            end
         endcase
      end
   end

   assign bus.req_ready_o   = ready_vec;
   assign bus.rsp_valid_o   = owner_vec;
   assign bus.rsp_allow_o   = (state_q == ST_RESP) && allow_q;
   assign bus.rsp_fault_o   = (state_q == ST_RESP) && fault_q;
   assign bus.rsp_cause_o   = (state_q == ST_RESP) ? cause_q : 3'd0;
   assign bus.rsp_flushed_o = (state_q == ST_RESP) && flushed_q;
   assign bus.rsp_timeout_o = (state_q == ST_RESP) && timeout_q;

   assign bus.walk_valid_o  = (state_q == ST_ISSUE);
   assign bus.walk_spa_o    = spa_q;
   assign bus.walk_access_o = access_q;
   assign bus.walk_flush_o  = (((state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE)) && flush_i)
                              || wd_expire;

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mpt_walk_arbiter
// Directed bench for mpt_walk_arbiter (NUM_REQ=3, XLEN=64, TIMEOUT_CYCLES=4).
// Expected responses are queued when a request is granted and compared by a
// negedge monitor whenever any rsp_* output is non-zero.
// ---------------------------------------------------------------------------
module tb_mpt_walk_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] mode;
   logic       flush;
   logic [1:0] dbg_state;

   int n_assert;
   int n_fail;

   // {rsp_valid[2:0], allow, fault, cause[2:0], flushed, timeout}
   logic [9:0] exp_q[$];

   logic [63:0] spa_v [3];
   logic [1:0]  acc_v [3];

   mpt_walk_arbiter_if #(.NUM_REQ(3), .XLEN(64)) bus ();

   mpt_walk_arbiter #(
      .NUM_REQ(3), .XLEN(64), .MODE_LEN(4), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mpt_mode_i  (mode),
      .flush_i     (flush),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] mk(input logic [2:0] oh, input logic a, input logic f,
                                     input logic [2:0] c, input logic fl, input logic to);
      return {oh, a, f, c, fl, to};
   endfunction

   function automatic logic [2:0] oh3(input int i);
      logic [2:0] v;
      v = 3'b000;
      v[i] = 1'b1;
      return v;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [9:0] obs;
      obs = {bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_fault_o, bus.rsp_cause_o,
             bus.rsp_flushed_o, bus.rsp_timeout_o};
      if (obs != 10'd0) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", 64'(obs), 64'(0));
         else                   chk("rsp", 64'(obs), 64'(exp_q.pop_front()));
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      n_assert = 0;
      n_fail   = 0;
      spa_v[0] = 64'h1000_2000_0000_3000;
      spa_v[1] = 64'h0000_0000_8000_1000;
      spa_v[2] = 64'hdead_beef_0000_0040;
      acc_v[0] = 2'b10;
      acc_v[1] = 2'b01;
      acc_v[2] = 2'b11;

      rst_n = 1'b0;
      mode  = 4'd0;
      flush = 1'b0;
      bus.req_valid_i  = 3'b111;
      bus.req_spa_i    = {spa_v[2], spa_v[1], spa_v[0]};
      bus.req_access_i = {acc_v[2], acc_v[1], acc_v[0]};
      bus.walk_ready_i = 1'b0;
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      bus.walk_fault_i = 1'b0;
      bus.walk_cause_i = 3'd0;

      // Reset state, with requests already pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready",  64'(bus.req_ready_o),   64'(0));
      chk("rst_rsp_valid",  64'(bus.rsp_valid_o),   64'(0));
      chk("rst_walk_valid", 64'(bus.walk_valid_o),  64'(0));
      chk("rst_walk_spa",   bus.walk_spa_o,         64'(0));
      chk("rst_walk_acc",   64'(bus.walk_access_o), 64'(0));
      chk("rst_walk_flush", 64'(bus.walk_flush_o),  64'(0));
      chk("rst_state",      64'(dbg_state),         64'(0));
      tick();
      rst_n = 1'b1;

      // Round-robin order 0,1,2,0 with all requesters valid; walker done
      // 3 cycles after ready. Mode goes to 0 mid-walk on the last one.
      mode = 4'd1;
      for (int w = 0; w < 4; w++) begin
         int   o;
         logic al;
         o  = w % 3;
         al = (w != 1);
         @(negedge clk);
         chk("grant_order", 64'(bus.req_ready_o), 64'(oh3(o)));
         exp_q.push_back(mk(oh3(o), al, 1'b0, 3'd0, 1'b0, 1'b0));
         tick();                               // ISSUE
         if (w == 3) mode = 4'd0;
         bus.walk_ready_i = 1'b1;
         @(negedge clk);
         chk("walk_valid",  64'(bus.walk_valid_o),  64'(1));
         chk("walk_spa",    bus.walk_spa_o,         spa_v[o]);
         chk("walk_access", 64'(bus.walk_access_o), 64'(acc_v[o]));
         tick();                               // WAIT_DONE c0
         bus.walk_ready_i = 1'b0;
         tick();                               // c1
         @(negedge clk);
         chk("no_grant_busy", 64'(bus.req_ready_o), 64'(0));
         tick();                               // c2
         bus.walk_done_i  = 1'b1;
         bus.walk_allow_i = al;
         tick();                               // RESP
         bus.walk_done_i  = 1'b0;
         bus.walk_allow_i = 1'b0;
         if (w == 3) begin
            mode = 4'd1;
            bus.req_valid_i = 3'b000;
         end
         tick();                               // IDLE
      end

      // Fault verdict, with walk_ready_i held low for 5 cycles.
      bus.req_valid_i = 3'b100;
      @(negedge clk);
      chk("fault_grant", 64'(bus.req_ready_o), 64'(3'b100));
      exp_q.push_back(mk(3'b100, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0));
      tick();                                  // ISSUE
      bus.req_valid_i = 3'b111;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("stall_walk_valid", 64'(bus.walk_valid_o), 64'(1));
         chk("stall_walk_spa",   bus.walk_spa_o,        spa_v[2]);
         chk("stall_no_grant",   64'(bus.req_ready_o),  64'(0));
         tick();
      end
      bus.walk_ready_i = 1'b1;
      tick();                                  // WAIT_DONE
      bus.walk_ready_i = 1'b0;
      bus.walk_done_i  = 1'b1;
      bus.walk_allow_i = 1'b0;
      bus.walk_fault_i = 1'b1;
      bus.walk_cause_i = 3'b010;
      tick();                                  // RESP
      bus.walk_done_i  = 1'b0;
      bus.walk_fault_i = 1'b0;
      bus.walk_cause_i = 3'd0;
      bus.req_valid_i  = 3'b000;
      tick();                                  // IDLE, rr_ptr=0

      // BARE bypass for requester 1.
      mode = 4'd0;
      bus.req_valid_i = 3'b010;
      @(negedge clk);
      chk("bypass_grant", 64'(bus.req_ready_o), 64'(3'b010));
      exp_q.push_back(mk(3'b010, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
      tick();                                  // RESP
      bus.req_valid_i = 3'b000;
      @(negedge clk);
      chk("bypass_no_walk", 64'(bus.walk_valid_o), 64'(0));
      tick();                                  // IDLE, rr_ptr=2

      // Back-to-back bypass requests from 0 and 2: expect 2,0,2.
      bus.req_valid_i = 3'b101;
      for (int b = 0; b < 3; b++) begin
         int o;
         o = (b == 1) ? 0 : 2;
         @(negedge clk);
         chk("b2b_grant", 64'(bus.req_ready_o), 64'(oh3(o)));
         exp_q.push_back(mk(oh3(o), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
         tick();                               // RESP
         if (b == 2) bus.req_valid_i = 3'b000;
         @(negedge clk);
         chk("b2b_resp_no_grant", 64'(bus.req_ready_o), 64'(0));
         tick();                               // IDLE
      end

      // Flush in the same cycle as walk_done_i with allow=1.
      mode = 4'd1;
      bus.req_valid_i = 3'b001;
      @(negedge clk);
      chk("flush_grant", 64'(bus.req_ready_o), 64'(3'b001));
      exp_q.push_back(mk(3'b001, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
      tick();                                  // ISSUE
      bus.req_valid_i  = 3'b000;
      bus.walk_ready_i = 1'b1;
      tick();                                  // WAIT_DONE
      bus.walk_ready_i = 1'b0;
      bus.walk_done_i  = 1'b1;
      bus.walk_allow_i = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_walk_flush", 64'(bus.walk_flush_o), 64'(1));
      tick();                                  // RESP
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_resp_no_pulse", 64'(bus.walk_flush_o), 64'(0));
      tick();                                  // IDLE, rr_ptr=1

      // Flush in IDLE blocks the grant; flush in RESP is ignored.
      flush = 1'b1;
      bus.req_valid_i = 3'b010;
      @(negedge clk);
      chk("idle_flush_no_grant", 64'(bus.req_ready_o), 64'(0));
      tick();
      @(negedge clk);
      chk("idle_flush_state", 64'(dbg_state), 64'(0));
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_grant", 64'(bus.req_ready_o), 64'(3'b010));
      exp_q.push_back(mk(3'b010, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0));
      tick();                                  // ISSUE
      bus.req_valid_i  = 3'b000;
      bus.walk_ready_i = 1'b1;
      tick();                                  // WAIT_DONE
      bus.walk_ready_i = 1'b0;
      bus.walk_done_i  = 1'b1;
      bus.walk_allow_i = 1'b1;
      tick();                                  // RESP
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      chk("resp_flush_ignored", 64'(bus.walk_flush_o), 64'(0));
      tick();                                  // IDLE, rr_ptr=2
      flush = 1'b0;

      // Reset in the middle of WAIT_DONE: no response, rr_ptr back to 0.
      bus.req_valid_i = 3'b100;
      @(negedge clk);
      chk("rstmid_grant", 64'(bus.req_ready_o), 64'(3'b100));
      tick();                                  // ISSUE
      bus.req_valid_i  = 3'b000;
      bus.walk_ready_i = 1'b1;
      tick();                                  // WAIT_DONE
      bus.walk_ready_i = 1'b0;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_walk_valid", 64'(bus.walk_valid_o),  64'(0));
      chk("rstmid_walk_spa",   bus.walk_spa_o,         64'(0));
      chk("rstmid_walk_acc",   64'(bus.walk_access_o), 64'(0));
      chk("rstmid_rsp_valid",  64'(bus.rsp_valid_o),   64'(0));
      chk("rstmid_state",      64'(dbg_state),         64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      bus.req_valid_i = 3'b111;
      @(negedge clk);
      chk("rstmid_rr_ptr", 64'(bus.req_ready_o), 64'(3'b001));

      // Watchdog: walker never finishes, TIMEOUT_CYCLES=4.
      exp_q.push_back(mk(3'b001, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1));
      tick();                                  // ISSUE
      bus.req_valid_i  = 3'b000;
      bus.walk_ready_i = 1'b1;
      tick();                                  // WAIT_DONE c0
      bus.walk_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("wd_no_flush_yet", 64'(bus.walk_flush_o), 64'(0));
         tick();
      end
      @(negedge clk);
      chk("wd_flush_pulse", 64'(bus.walk_flush_o), 64'(1));
      tick();                                  // RESP
      @(negedge clk);
      chk("wd_flush_once", 64'(bus.walk_flush_o), 64'(0));
      tick();                                  // IDLE

      // Stray walk_done_i in IDLE must not produce a response.
      bus.walk_done_i  = 1'b1;
      bus.walk_allow_i = 1'b1;
      tick();
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      @(negedge clk);
      chk("stray_done_state", 64'(dbg_state), 64'(0));

      repeat (3) tick();
      chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
